// File: rtl/icache_fetch_pkg.sv
// Shared types and address-field helpers for the fetch stage and its I-cache.
// Field helpers work on a zero-extended 64-bit address; callers size-cast the result.
package icache_fetch_pkg;

    typedef enum logic {
        IDLE,
        REFILL
    } state_e;

    localparam int ADDR_W_DEF = 32;
    localparam int LINES_DEF  = 128;
    localparam int WPL_DEF    = 4;

    localparam int WB    = $clog2(WPL_DEF);
    localparam int IB    = $clog2(LINES_DEF);
    localparam int TAG_W = ADDR_W_DEF - 2 - WB - IB;

    function automatic logic [63:0] word_of(
        input logic [63:0] a,
        input int unsigned wb
    );
        return (a >> 2) & ((64'd1 << wb) - 64'd1);
    endfunction

    function automatic logic [63:0] index_of(
        input logic [63:0] a,
        input int unsigned wb,
        input int unsigned ib
    );
        return (a >> (2 + wb)) & ((64'd1 << ib) - 64'd1);
    endfunction

    function automatic logic [63:0] tag_of(
        input logic [63:0] a,
        input int unsigned wb,
        input int unsigned ib
    );
        return a >> (2 + wb + ib);
    endfunction

    function automatic logic [63:0] line_of(
        input logic [63:0] a,
        input int unsigned wb
    );
        return a & ~((64'd4 << wb) - 64'd1);
    endfunction

endpackage

// File: rtl/icache_refill_fsm.sv
// Line refill sequencer: walks the words of one line, tracking which have arrived.
// Owns the memory request interface and tells the top which word to write.
module icache_refill_fsm
    import icache_fetch_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int WORDS_PER_LINE = 4,
    localparam int WI = (WORDS_PER_LINE > 1) ? $clog2(WORDS_PER_LINE) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      rdy,
    input  logic                      flush,
    input  logic                      miss,
    input  logic [ADDR_W-1:0]         line_addr,
    input  logic                      mem_valid,
    input  logic [ADDR_W-1:0]         mem_resp_addr,
    output logic                      busy,
    output logic                      start,
    output logic                      wr_en,
    output logic                      wr_last,
    output logic                      mem_req,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic [ADDR_W-1:0]         fill_base,
    output logic [WI-1:0]             fill_idx,
    output logic [WORDS_PER_LINE-1:0] fill_got
);

    state_e state;
    logic   last;
    logic   match;

    assign busy    = (state == REFILL);
    assign last    = (fill_idx == WI'(WORDS_PER_LINE - 1));
    assign match   = ((mem_resp_addr & ~ADDR_W'(3)) == mem_addr);
    assign start   = rdy && !flush && miss && (state == IDLE);
    assign wr_en   = rdy && !flush && busy && mem_valid && match;
    assign wr_last = wr_en && last;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            mem_req   <= 1'b0;
            mem_addr  <= '0;
            fill_base <= '0;
            fill_idx  <= '0;
            fill_got  <= '0;
        end else if (rdy) begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state     <= REFILL;
                        mem_req   <= 1'b1;
                        mem_addr  <= line_addr;
                        fill_base <= line_addr;
                        fill_idx  <= '0;
                        fill_got  <= '0;
                    end
                end
                REFILL: begin
                    // flush wins even over the final word
                    if (flush) begin
                        state   <= IDLE;
                        mem_req <= 1'b0;
                    end else if (wr_en) begin
                        fill_got[fill_idx] <= 1'b1;
                        if (last) begin
                            state   <= IDLE;
                            mem_req <= 1'b0;
                        end else begin
                            fill_idx <= fill_idx + 1'b1;
                            mem_addr <= mem_addr + ADDR_W'(4);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/icache_fetch.sv
// Fetch stage with a direct-mapped I-cache; serves hits, filled words
// and in-flight memory words while a line refill is running.
module icache_fetch
    import icache_fetch_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int INST_W = 32,
    parameter int LINES = 128,
    parameter int WORDS_PER_LINE = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              flush,
    input  logic [ADDR_W-1:0] fpc,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_valid,
    input  logic [ADDR_W-1:0] mem_resp_addr,
    input  logic [INST_W-1:0] mem_data,
    output logic              stall_request,
    output logic [ADDR_W-1:0] npc,
    output logic [INST_W-1:0] inst
);

    localparam int WBITS = $clog2(WORDS_PER_LINE);
    localparam int WI    = (WBITS > 0) ? WBITS : 1;
    localparam int IBITS = $clog2(LINES);
    localparam int TBITS = ADDR_W - 2 - WBITS - IBITS;

    logic [LINES-1:0]  valid;
    logic [TBITS-1:0]  tags [LINES];
    logic [INST_W-1:0] data [LINES][WORDS_PER_LINE];

    logic [IBITS-1:0]  fpc_idx;
    logic [WI-1:0]     fpc_word;
    logic [TBITS-1:0]  fpc_tag;
    logic [ADDR_W-1:0] fpc_line;
    logic [IBITS-1:0]  fill_index;
    logic [TBITS-1:0]  fill_tag;

    logic                      busy;
    logic                      start;
    logic                      wr_en;
    logic                      wr_last;
    logic [ADDR_W-1:0]         fill_base;
    logic [WI-1:0]             fill_idx;
    logic [WORDS_PER_LINE-1:0] fill_got;

    logic hit;
    logic filled;
    logic bypass;

    assign fpc_idx    = IBITS'(index_of(64'(fpc), WBITS, IBITS));
    assign fpc_word   = WI'(word_of(64'(fpc), WBITS));
    assign fpc_tag    = TBITS'(tag_of(64'(fpc), WBITS, IBITS));
    assign fpc_line   = ADDR_W'(line_of(64'(fpc), WBITS));
    assign fill_index = IBITS'(index_of(64'(fill_base), WBITS, IBITS));
    assign fill_tag   = TBITS'(tag_of(64'(fill_base), WBITS, IBITS));

    assign hit    = valid[fpc_idx] && (tags[fpc_idx] == fpc_tag);
    assign filled = busy && (fpc_line == fill_base) && fill_got[fpc_word];
    assign bypass = mem_valid &&
                    ((mem_resp_addr & ~ADDR_W'(3)) == (fpc & ~ADDR_W'(3)));

    icache_refill_fsm #(
        .ADDR_W(ADDR_W),
        .WORDS_PER_LINE(WORDS_PER_LINE)
    ) u_fsm (
        .clk(clk),
        .rst(rst),
        .rdy(rdy),
        .flush(flush),
        .miss(!hit),
        .line_addr(fpc_line),
        .mem_valid(mem_valid),
        .mem_resp_addr(mem_resp_addr),
        .busy(busy),
        .start(start),
        .wr_en(wr_en),
        .wr_last(wr_last),
        .mem_req(mem_req),
        .mem_addr(mem_addr),
        .fill_base(fill_base),
        .fill_idx(fill_idx),
        .fill_got(fill_got)
    );

    // the victim index is dropped up front so its old tag never sees new words
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= '0;
        end else if (rdy) begin
            if (flush) begin
                valid <= '0;
            end else begin
                if (start) valid[fpc_idx] <= 1'b0;
                if (wr_last) valid[fill_index] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            data[fill_index][fill_idx] <= mem_data;
            if (wr_last) tags[fill_index] <= fill_tag;
        end
    end

    always_comb begin
        inst          = '0;
        npc           = '0;
        stall_request = 1'b0;
        if (rst) begin
            stall_request = 1'b0;
        end else if (hit || filled) begin
            inst = data[fpc_idx][fpc_word];
            npc  = fpc;
        end else if (bypass) begin
            inst = mem_data;
            npc  = fpc;
        end else begin
            stall_request = 1'b1;
        end
    end

endmodule
